// File: rtl/ahblite_ir_keyq.sv
// AHB-lite IR key queue: optional repeat filter (IR_KEYQ_REPEAT_FILTER_EN) feeding a DEPTH-entry FIFO popped by DATA reads.
// Latency: key sampled at edge N is counted at N+1 and raises key_irq at N+2; bus is zero-wait-state.
// Backpressure: none toward the decoder; keys arriving at a full FIFO are dropped and flagged as sticky overflow.
module ahblite_ir_keyq #(
    parameter int DEPTH         = 16,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        key_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    logic       rd_q, wr_q;
    logic [1:0] addr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 2'd0;
        end else if (HREADY) begin
            rd_q   <= HSEL & HTRANS[1] & ~HWRITE;
            wr_q   <= HSEL & HTRANS[1] & HWRITE;
            addr_q <= HADDR[3:2];
        end
    end

    logic ctrl_we, clr_we;
    assign ctrl_we = wr_q & HREADY & (addr_q == 2'd2);
    assign clr_we  = wr_q & HREADY & (addr_q == 2'd3);

    logic cap_en_q, irq_en_q, filt_en;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cap_en_q <= 1'b1;
            irq_en_q <= 1'b0;
        end else if (ctrl_we) begin
            cap_en_q <= HWDATA[0];
            irq_en_q <= HWDATA[1];
        end
    end

    // Decoder output is registered once so the filter and FIFO see a clean stage.
    logic       kv_q;
    logic [7:0] kc_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            kv_q <= 1'b0;
            kc_q <= 8'd0;
        end else begin
            kv_q <= key_valid;
            if (key_valid) kc_q <= key_code;
        end
    end

    logic cap_key, key_pass;
    assign cap_key = kv_q & cap_en_q;

`ifdef IR_KEYQ_REPEAT_FILTER_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam int TW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(REPEAT_CYCLES);

    logic          filt_en_q;
    logic [0:0]    st_q;
    logic [TW-1:0] tmr_q;
    logic [7:0]    last_q;

    assign filt_en = filt_en_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     filt_en_q <= 1'b0;
        else if (ctrl_we) filt_en_q <= HWDATA[2];
    end

    always_comb begin
        key_pass = cap_key;
        if (filt_en_q && (st_q == ST_HOLD) && (kc_q == last_q)) key_pass = 1'b0;
    end

    // Every captured key, accepted or suppressed, restarts the hold-off window.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st_q   <= ST_IDLE;
            tmr_q  <= '0;
            last_q <= 8'd0;
        end else if (!filt_en_q) begin
            st_q  <= ST_IDLE;
            tmr_q <= '0;
        end else if (cap_key) begin
            st_q   <= ST_HOLD;
            tmr_q  <= TMR_LOAD;
            last_q <= kc_q;
        end else if (st_q == ST_HOLD) begin
            if (tmr_q <= TW'(1)) begin
                tmr_q <= '0;
                st_q  <= ST_IDLE;
            end else begin
                tmr_q <= tmr_q - TW'(1);
            end
        end
    end
`else
    assign filt_en  = 1'b0;
    assign key_pass = cap_key;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          empty, full, flush, clr_ovf, do_pop, do_push, ovf_set;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign flush   = clr_we & HWDATA[0];
    assign clr_ovf = clr_we & HWDATA[1];
    assign do_pop  = rd_q & HREADY & (addr_q == 2'd0) & ~empty & ~flush;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push = key_pass & (~full | do_pop) & ~flush;
    assign ovf_set = key_pass & full & ~do_pop & ~flush;

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wp_q] <= kc_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ovf_q   <= 1'b0;
            key_irq <= 1'b0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            key_irq <= irq_en_q & (~empty | ovf_q);
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (rd_q) begin
            case (addr_q)
                2'd0:    HRDATA = empty ? 32'd0 : {23'd0, 1'b1, mem[rp_q]};
                2'd1:    HRDATA = {21'd0, ovf_q, full, empty, 1'b0, 7'(cnt_q)};
                2'd2:    HRDATA = {29'd0, filt_en, irq_en_q, cap_en_q};
                default: HRDATA = 32'd0;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:2]};

endmodule

// File: doc/ahblite_ir_keyq.md
# ahblite_ir_keyq

AHB-lite peripheral that queues key codes from the infrared remote decoder behind a programmable interrupt and sequences their delivery to the Cortex-M0. Incoming codes pass a repeat filter and are buffered in a FIFO of `DEPTH` entries; software pops them one per read. The block sits on the AHB-lite bus matrix next to the other game peripherals. It replaces direct polling of the decoder's single 8-bit latch.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..64.
- `REPEAT_CYCLES`, 5000000: repeat-filter hold-off in HCLK cycles (100 ms at 50 MHz); must be ≥1.
- `HCLK` in 1: the single clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL`, `HADDR[31:0]`, `HTRANS[1:0]`, `HSIZE[2:0]`, `HPROT[3:0]`, `HWRITE`, `HWDATA[31:0]`, `HREADY` in: AHB-lite slave inputs. Only `HADDR[3:2]` is decoded; `HSIZE` and `HPROT` are ignored.
- `HREADYOUT` out 1: tied 1.
- `HRESP` out 1: tied 0.
- `HRDATA` out 32: read data.
- `key_valid` in 1: one-HCLK-cycle pulse from the decoder when a code is received.
- `key_code` in 8: decoder code; valid only while `key_valid` is high.
- `key_irq` out 1: registered, level-sensitive interrupt.

## Operation
- Register map, word offsets:
  - 0x0 DATA (RO): `{23'b0, nonempty, head[7:0]}`. A read that finds the FIFO non-empty pops the head. A read of an empty FIFO returns 0 and pops nothing.
  - 0x4 STATUS (RO): `[6:0]` count, `[8]` empty, `[9]` full, `[10]` overflow (sticky).
  - 0x8 CTRL (RW): `[0]` cap_en, `[1]` irq_en, `[2]` filt_en. Other bits read 0. Reset value 0x1.
  - 0xC CLEAR (WO, reads 0): `[0]` flush FIFO (count←0, pointers←0), `[1]` clear overflow.
- Acceptance path: `key_valid` → (cap_en) → repeat filter → FIFO push.
  - With cap_en=0, codes are dropped silently and overflow is unaffected.
- Repeat filter FSM (HCLK domain), states IDLE and HOLD; 32-bit-safe down-counter `tmr` of width $clog2(REPEAT_CYCLES+1).
  - IDLE: a key is accepted; `last`←code; `tmr`←REPEAT_CYCLES; go to HOLD.
  - HOLD, same code: key dropped; `tmr` reloaded, so a held button stays suppressed.
  - HOLD, different code: key accepted; `last` and `tmr` updated; stay in HOLD.
  - HOLD, no key: `tmr` decrements; when it reaches 0 the FSM goes to IDLE.
  - filt_en=0: FSM forced to IDLE; every key is accepted.
- FIFO: circular buffer with wrap-around pointers and a separate count.
  - Push when full: code dropped; overflow←1.
  - Push and pop in the same cycle: both execute; count is unchanged. When full, the pop frees the slot and the push succeeds.
  - Flush together with a push or pop: flush wins and the incoming key is discarded.
  - Clear-overflow together with a new overflow event: overflow stays 1.
- Interrupt: `key_irq` ← irq_en & (~empty | overflow), registered.

## Timing
- Address phase: `HADDR[3:2]` and the read/write qualifiers are registered when HSEL & HREADY & HTRANS[1].
- Writes: `HWDATA` is applied at the end of the data phase. CTRL and CLEAR take effect on the following edge.
- Reads: `HRDATA` is combinational from registered state during the data phase, and 0 outside a read data phase. The DATA pop occurs on the edge that ends the data phase.
- Back-to-back DATA reads pop successive entries with zero wait states.
- Key-to-FIFO latency: a `key_valid` at edge N makes the entry visible in count at N+1. `key_irq` asserts at N+2.
- Reset (async assert, sync-to-HCLK deassert by the system):
  - count 0, pointers 0, overflow 0, CTRL 0x1, FSM IDLE, `tmr` 0, `key_irq` 0, `HRDATA` 0.
  - Reset mid-transfer aborts the transfer; FIFO contents are discarded.

## Configuration
- `IR_KEYQ_REPEAT_FILTER_EN` defined: the repeat-filter FSM and `tmr` are present as described.
- Undefined: no FSM or timer is built; every captured key goes to the FIFO; CTRL[2] is read-only 0 and writes to it are ignored.

## Test plan
- Reset, then read STATUS → 0x100; read DATA → 0; `key_irq`=0.
- CTRL=0x3; pulse codes 0x45, 0x46 with filt_en=0 → STATUS count 2 and `key_irq`=1 two cycles after the first pulse. DATA reads return 0x145, then 0x146, then 0; `key_irq` drops after the second pop.
- Push 17 codes with DEPTH=16 → STATUS 0x610. Write CLEAR=0x2 → overflow 0. Write CLEAR=0x1 → 0x100.
- With the FIFO full, push and pop in the same cycle → count remains 16, no overflow, and the new code is last out.
- Filter on, REPEAT_CYCLES=100: 0x18 at t=0, 0x18 at t=50, 0x18 at t=140 → one entry (the t=140 repeat was seen at tmr≠0 after the t=50 reload). 0x18 at t=300 → second entry. 0x5A at t=305 → third entry.
- Assert HRESETn low while 5 entries are queued and a DATA read is in flight → all outputs return to reset values immediately; STATUS reads 0x100 after release.
